// File: rtl/if_pkg.sv
// Shared types and defaults for the IF/ID fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam int          CNT_W_DEFAULT     = 32;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_WAIT,
    FS_ERR
  } fetch_state_t;

endpackage

// File: rtl/if_perf_counters.sv
// Three free-running, enable-driven event counters for the fetch stage.
module if_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_instr,
  input  logic             en_bubble,
  input  logic             en_stall,
  output logic [CNT_W-1:0] cnt_instr,
  output logic [CNT_W-1:0] cnt_bubble,
  output logic [CNT_W-1:0] cnt_stall
);

  logic [CNT_W-1:0] r_cnt_instr;
  logic [CNT_W-1:0] r_cnt_bubble;
  logic [CNT_W-1:0] r_cnt_stall;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_instr  <= '0;
      r_cnt_bubble <= '0;
      r_cnt_stall  <= '0;
    end else begin
      if (en_instr)  r_cnt_instr  <= r_cnt_instr  + CNT_W'(1);
      if (en_bubble) r_cnt_bubble <= r_cnt_bubble + CNT_W'(1);
      if (en_stall)  r_cnt_stall  <= r_cnt_stall  + CNT_W'(1);
    end
  end

  assign cnt_instr  = r_cnt_instr;
  assign cnt_bubble = r_cnt_bubble;
  assign cnt_stall  = r_cnt_stall;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush/wait bubbles, hazard hold and a fetch watchdog.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_id_stage
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int          TIMEOUT   = 16
`ifdef IF_PERF_CNT_EN
  ,
  parameter int          CNT_W     = CNT_W_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  output logic        fetch_stall,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        fetch_timeout
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_instr,
  output logic [CNT_W-1:0] cnt_bubble,
  output logic [CNT_W-1:0] cnt_stall
`endif
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  fetch_state_t    r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_timeout;
  logic [31:0]     r_pc_d;
  logic [31:0]     r_instr_d;
  logic            r_valid_d;

  logic w_hold;
  logic w_bubble;
  logic w_capture;

  // Once the watchdog has fired, every fetch is treated as wrong-path.
  assign w_hold    = hazard_stall;
  assign w_bubble  = !hazard_stall && (branch_taken || !imem_valid || (r_state == FS_ERR));
  assign w_capture = !hazard_stall && !w_bubble;

  assign fetch_stall = !imem_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_d    <= '0;
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (w_bubble) begin
      r_pc_d    <= pc_f;
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (w_capture) begin
      r_pc_d    <= pc_f;
      r_instr_d <= imem_rdata;
      r_valid_d <= 1'b1;
    end
  end

  // Watchdog runs independently of hazard_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FS_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        FS_RUN: begin
          if (!imem_valid) begin
            r_state    <= FS_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        FS_WAIT: begin
          if (imem_valid) begin
            r_state    <= FS_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WC_W'(TIMEOUT)) begin
            r_state   <= FS_ERR;
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        default: begin
          r_state <= FS_ERR;
        end
      endcase
    end
  end

  assign pc_d          = r_pc_d;
  assign instr_d       = r_instr_d;
  assign valid_d       = r_valid_d;
  assign fetch_timeout = r_timeout;

`ifdef IF_PERF_CNT_EN
  if_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .en_instr  (w_capture),
    .en_bubble (w_bubble),
    .en_stall  (w_hold),
    .cnt_instr (cnt_instr),
    .cnt_bubble(cnt_bubble),
    .cnt_stall (cnt_stall)
  );
`else
  logic w_unused_hold;
  assign w_unused_hold = w_hold;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage; counter checks are built when IF_PERF_CNT_EN is defined.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        hazard_stall;
  logic        branch_taken;

  logic        a_fetch_stall, a_valid_d, a_timeout;
  logic [31:0] a_pc_d, a_instr_d;
  logic        b_fetch_stall, b_valid_d, b_timeout;
  logic [31:0] b_pc_d, b_instr_d;
  logic        c_fetch_stall, c_valid_d, c_timeout;
  logic [31:0] c_pc_d, c_instr_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef IF_PERF_CNT_EN
  logic [31:0] a_cnt_instr, a_cnt_bubble, a_cnt_stall;
  logic [31:0] b_cnt_instr, b_cnt_bubble, b_cnt_stall;
  logic [31:0] c_cnt_instr, c_cnt_bubble, c_cnt_stall;
  logic        d_fetch_stall, d_valid_d, d_timeout;
  logic [31:0] d_pc_d, d_instr_d;
  logic [3:0]  d_cnt_instr, d_cnt_bubble, d_cnt_stall;
`endif

  // TIMEOUT=16 reference instance
  if_id_stage #(.TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .pc_f(pc_f), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken), .fetch_stall(a_fetch_stall),
    .pc_d(a_pc_d), .instr_d(a_instr_d), .valid_d(a_valid_d), .fetch_timeout(a_timeout)
`ifdef IF_PERF_CNT_EN
    , .cnt_instr(a_cnt_instr), .cnt_bubble(a_cnt_bubble), .cnt_stall(a_cnt_stall)
`endif
  );

  if_id_stage #(.TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .pc_f(pc_f), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken), .fetch_stall(b_fetch_stall),
    .pc_d(b_pc_d), .instr_d(b_instr_d), .valid_d(b_valid_d), .fetch_timeout(b_timeout)
`ifdef IF_PERF_CNT_EN
    , .cnt_instr(b_cnt_instr), .cnt_bubble(b_cnt_bubble), .cnt_stall(b_cnt_stall)
`endif
  );

  if_id_stage #(.TIMEOUT(1)) u_c (
    .clk(clk), .rst(rst), .pc_f(pc_f), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken), .fetch_stall(c_fetch_stall),
    .pc_d(c_pc_d), .instr_d(c_instr_d), .valid_d(c_valid_d), .fetch_timeout(c_timeout)
`ifdef IF_PERF_CNT_EN
    , .cnt_instr(c_cnt_instr), .cnt_bubble(c_cnt_bubble), .cnt_stall(c_cnt_stall)
`endif
  );

`ifdef IF_PERF_CNT_EN
  if_id_stage #(.TIMEOUT(16), .CNT_W(4)) u_d (
    .clk(clk), .rst(rst), .pc_f(pc_f), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken), .fetch_stall(d_fetch_stall),
    .pc_d(d_pc_d), .instr_d(d_instr_d), .valid_d(d_valid_d), .fetch_timeout(d_timeout),
    .cnt_instr(d_cnt_instr), .cnt_bubble(d_cnt_bubble), .cnt_stall(d_cnt_stall)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_f = 32'h0; imem_rdata = 32'h0; imem_valid = 1'b1;
    hazard_stall = 1'b0; branch_taken = 1'b0;
    step();
    step();
    checks++;
    if (a_pc_d !== 32'h0 || a_instr_d !== 32'h0000_0013 || a_valid_d !== 1'b0 || a_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b to=%b, want 0/00000013/0/0",
               a_pc_d, a_instr_d, a_valid_d, a_timeout);
    end
    imem_valid = 1'b0;
    #1;
    checks++;
    if (a_fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_masks_fetch_stall: got %b want 0", a_fetch_stall);
    end
    imem_valid = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_capture();
    pc_f = 32'h0; imem_rdata = 32'h0050_0093; imem_valid = 1'b1;
    step();
    checks++;
    if (a_pc_d !== 32'h0 || a_instr_d !== 32'h0050_0093 || a_valid_d !== 1'b1) begin
      errors++;
      $display("FAIL capture: pc=%h instr=%h valid=%b, want 0/00500093/1", a_pc_d, a_instr_d, a_valid_d);
    end
  endtask

  task automatic test_hazard_stall();
    pc_f = 32'h4; imem_rdata = 32'hAAAA_0001;
    step();
    hazard_stall = 1'b1; pc_f = 32'h8; imem_rdata = 32'hBBBB_0002;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_pc_d !== 32'h4 || a_instr_d !== 32'hAAAA_0001 || a_valid_d !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h valid=%b, want 4/aaaa0001/1",
                 i, a_pc_d, a_instr_d, a_valid_d);
      end
    end
    hazard_stall = 1'b0;
    step();
    checks++;
    if (a_pc_d !== 32'h8 || a_instr_d !== 32'hBBBB_0002 || a_valid_d !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: pc=%h instr=%h valid=%b, want 8/bbbb0002/1", a_pc_d, a_instr_d, a_valid_d);
    end
  endtask

  task automatic test_flush();
    pc_f = 32'hC; imem_rdata = 32'hDEAD_BEEF; branch_taken = 1'b1;
    step();
    checks++;
    if (a_pc_d !== 32'hC || a_instr_d !== 32'h0000_0013 || a_valid_d !== 1'b0) begin
      errors++;
      $display("FAIL flush: pc=%h instr=%h valid=%b, want c/00000013/0", a_pc_d, a_instr_d, a_valid_d);
    end
    branch_taken = 1'b0; pc_f = 32'h10; imem_rdata = 32'hCCCC_0003;
    step();
    branch_taken = 1'b1; hazard_stall = 1'b1; pc_f = 32'h14; imem_rdata = 32'h1234_5678;
    step();
    checks++;
    if (a_pc_d !== 32'h10 || a_instr_d !== 32'hCCCC_0003 || a_valid_d !== 1'b1) begin
      errors++;
      $display("FAIL stall_plus_flush: pc=%h instr=%h valid=%b, want 10/cccc0003/1", a_pc_d, a_instr_d, a_valid_d);
    end
    branch_taken = 1'b0; hazard_stall = 1'b0;
  endtask

  task automatic test_mem_wait();
    logic [31:0] pcs [3];
    pcs[0] = 32'h18; pcs[1] = 32'h1C; pcs[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'b0; pc_f = pcs[i]; imem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (a_fetch_stall !== 1'b1) begin
        errors++;
        $display("FAIL wait_fetch_stall[%0d]: got %b want 1", i, a_fetch_stall);
      end
      step();
      checks++;
      if (a_pc_d !== pcs[i] || a_instr_d !== 32'h0000_0013 || a_valid_d !== 1'b0) begin
        errors++;
        $display("FAIL wait_bubble[%0d]: pc=%h instr=%h valid=%b, want %h/00000013/0",
                 i, a_pc_d, a_instr_d, a_valid_d, pcs[i]);
      end
      if (i < 2) begin
        checks++;
        if (c_timeout !== (i == 1)) begin
          errors++;
          $display("FAIL timeout1_after_wait%0d: got %b want %b", i + 1, c_timeout, (i == 1));
        end
      end
    end
    imem_valid = 1'b1; pc_f = 32'h24; imem_rdata = 32'h0011_2233;
    #1;
    checks++;
    if (a_fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL wait_release_stall: got %b want 0", a_fetch_stall);
    end
    step();
    checks++;
    if (a_pc_d !== 32'h24 || a_instr_d !== 32'h0011_2233 || a_valid_d !== 1'b1 || a_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wait_capture: pc=%h instr=%h valid=%b to=%b, want 24/00112233/1/0",
               a_pc_d, a_instr_d, a_valid_d, a_timeout);
    end
  endtask

  task automatic test_watchdog();
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_valid = 1'b0; pc_f = 32'h40;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (b_timeout !== (i == 5) || a_timeout !== 1'b0) begin
        errors++;
        $display("FAIL watchdog_wait%0d: to4=%b want %b, to16=%b want 0", i, b_timeout, (i == 5), a_timeout);
      end
    end
    imem_valid = 1'b1; pc_f = 32'h44; imem_rdata = 32'h5555_AAAA;
    step();
    checks++;
    if (b_timeout !== 1'b1 || b_valid_d !== 1'b0 || b_instr_d !== 32'h0000_0013) begin
      errors++;
      $display("FAIL watchdog_sticky: to=%b valid=%b instr=%h, want 1/0/00000013", b_timeout, b_valid_d, b_instr_d);
    end
    checks++;
    if (a_valid_d !== 1'b1 || a_instr_d !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL watchdog_other_capture: valid=%b instr=%h, want 1/5555aaaa", a_valid_d, a_instr_d);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (b_timeout !== 1'b0 || b_valid_d !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_rst_clear: to=%b valid=%b, want 0/0", b_timeout, b_valid_d);
    end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_counters();
    rst = 1'b1; imem_valid = 1'b1; hazard_stall = 1'b0; branch_taken = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin pc_f = 32'(i * 4); imem_rdata = 32'(i); step(); end
    branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) step();
    branch_taken = 1'b0; hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    hazard_stall = 1'b0;
    checks++;
    if (a_cnt_instr !== 32'd5 || a_cnt_bubble !== 32'd2 || a_cnt_stall !== 32'd3) begin
      errors++;
      $display("FAIL perf_counts: instr=%0d bubble=%0d stall=%0d, want 5/2/3", a_cnt_instr, a_cnt_bubble, a_cnt_stall);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) step();
    checks++;
    if (d_cnt_instr !== 4'd1 || a_cnt_instr !== 32'd17) begin
      errors++;
      $display("FAIL perf_wrap: cnt4=%0d want 1, cnt32=%0d want 17", d_cnt_instr, a_cnt_instr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_hazard_stall();
    test_flush();
    test_mem_wait();
    test_watchdog();
`ifdef IF_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
